radix3_out_serializer: RTL and testbench

Output-side companion to the radix-3 butterfly (radix_3_top). It captures each complex float32 triplet (A, B, C) after the butterfly's fixed pipeline latency and buffers it in a triplet FIFO. It then serializes the buffered triplets into a single-sample valid/ready stream for the next FFT stage or the result memory. Issue credits back-pressure the upstream sequencer, so no triplet is lost while the sequencer honours in_ready.

---
 rtl/radix3_out_serializer_if.sv | 44 ++++
 rtl/radix3_out_serializer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_radix3_out_serializer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/radix3_out_serializer_if.sv
// -----------------------------------------------------------------------------
// radix3_out_serializer_if
// Single-sample output stream of the radix-3 output serializer.
//
// Signals:
//   out_valid  producer -> consumer  sample available
//   out_ready  consumer -> producer  sample accepted this cycle
//   out_re     producer -> consumer  real part of the sample (W bits)
//   out_img    producer -> consumer  imaginary part of the sample (W bits)
//   out_idx    producer -> consumer  0=A, 1=B, 2=C position within the triplet
//   out_last   producer -> consumer  high on the C beat of a triplet
//
// Modports:
//   master  the serializer (drives the stream)
//   slave   the next FFT stage or result memory (accepts the stream)
// -----------------------------------------------------------------------------
interface radix3_out_serializer_if #(
    parameter int W = 32
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re;
    logic [W-1:0] out_img;
    logic [1:0]   out_idx;
    logic         out_last;

    modport master (
        output out_valid,
        output out_re,
        output out_img,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_re,
        input  out_img,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/radix3_out_serializer.sv
// -----------------------------------------------------------------------------
// radix3_out_serializer
// Output-side companion of the radix-3 butterfly. Each accepted issue is
// tracked through a LATENCY-deep delay line; when it emerges, the six
// butterfly output words (A, B, C complex) are written into a triplet FIFO.
// The FIFO head is then streamed out one complex sample per beat (A, B, C).
// Issue credits bound the number of triplets in flight plus buffered to
// DEPTH, so the FIFO can never be written while full as long as the upstream
// sequencer honours in_ready.
//
// Parameters:
//   W        word width of one real/imag component (bit-exact passthrough)
//   LATENCY  butterfly pipeline latency in cycles (>= 1)
//   DEPTH    triplet FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, dominates all other inputs
//   in_valid   a triplet is being presented to the butterfly this cycle
//   in_ready   an issue credit is free (depends on registers only)
//   ao_*/bo_*/co_*  butterfly outputs, valid LATENCY cycles after issue
//   out_if     serialized sample stream (master side)
//   overflow   sticky: in_valid seen while in_ready was low
//   level      FIFO occupancy in triplets
// -----------------------------------------------------------------------------
module radix3_out_serializer #(
    parameter int W       = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           ao_re,
    input  logic [W-1:0]           ao_img,
    input  logic [W-1:0]           bo_re,
    input  logic [W-1:0]           bo_img,
    input  logic [W-1:0]           co_re,
    input  logic [W-1:0]           co_img,
    radix3_out_serializer_if.master out_if,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 6 * W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_INC = AW'(1);

    // Word slots inside a packed triplet {ao_re, ao_img, bo_re, bo_img, co_re, co_img}
    localparam int SL_AO_RE  = 5;
    localparam int SL_AO_IMG = 4;
    localparam int SL_BO_RE  = 3;
    localparam int SL_BO_IMG = 2;
    localparam int SL_CO_RE  = 1;
    localparam int SL_CO_IMG = 0;

    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_B = 2'd1,
        PH_C = 2'd2
    } phase_t;

    // Pick one W-bit word out of a packed triplet.
    function automatic logic [W-1:0] sel_word(input logic [TW-1:0] trip, input int slot);
        return trip[slot*W +: W];
    endfunction

    logic [CW-1:0]      credits_r;
    logic [LATENCY-1:0] dly_r;
    logic [TW-1:0]      mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      level_r;
    logic               overflow_r;
    phase_t             phase_r;
    phase_t             phase_nx;

    logic               in_ready_s;
    logic               accept_s;
    logic               reject_s;
    logic               empty_s;
    logic               full_s;
    logic               wr_en_s;
    logic               wr_do_s;
    logic               beat_s;
    logic               pop_s;
    logic [TW-1:0]      head_s;
    logic [W-1:0]       re_s;
    logic [W-1:0]       img_s;

    // Handshake decode: credits, FIFO flags, capture strobe, beat/pop events.
    always_comb begin
        in_ready_s = (credits_r < DEPTH_C);
        accept_s   = in_valid && in_ready_s;
        reject_s   = in_valid && !in_ready_s;
        empty_s    = (level_r == {CW{1'b0}});
        full_s     = (level_r == DEPTH_C);
        // The issue bit leaving the last tap marks the cycle the butterfly
        // outputs belong to this triplet.
        wr_en_s    = dly_r[LATENCY-1];
        beat_s     = !empty_s && out_if.out_ready;
        pop_s      = beat_s && (phase_r == PH_C);
        // A pop on the same edge frees the slot, so a write into a full FIFO
        // is still safe then; otherwise a write into a full FIFO is dropped
        // rather than corrupting the head.
        wr_do_s    = wr_en_s && (!full_s || pop_s);
    end

    // Issue credit counter: +1 on accepted issue, -1 on triplet pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   credits_r <= credits_r + ONE_C;
                2'b01:   credits_r <= credits_r - ONE_C;
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Delay line tracking accepted issues through the butterfly pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_r <= {LATENCY{1'b0}};
        end else begin
            dly_r[0] <= accept_s;
            for (int i = 1; i < LATENCY; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Triplet storage; contents are only observable while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (wr_do_s) begin
            mem_r[wr_ptr_r] <= {ao_re, ao_img, bo_re, bo_img, co_re, co_img};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {CW{1'b0}};
        end else begin
            if (wr_do_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_INC;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
            case ({wr_do_s, pop_s})
                2'b10:   level_r <= level_r + ONE_C;
                2'b01:   level_r <= level_r - ONE_C;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow flag for issues presented without a credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (reject_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Beat phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= PH_A;
        end else begin
            phase_r <= phase_nx;
        end
    end

    // Beat phase next-state: advance on every accepted beat, C returns to A.
    always_comb begin
        phase_nx = phase_r;
        if (beat_s) begin
            case (phase_r)
                PH_A:    phase_nx = PH_B;
                PH_B:    phase_nx = PH_C;
                PH_C:    phase_nx = PH_A;
                default: phase_nx = PH_A;
            endcase
        end else begin
            phase_nx = phase_r;
        end
    end

    // Read mux: select the complex word of the head triplet for this phase.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        re_s   = {W{1'b0}};
        img_s  = {W{1'b0}};
        if (!empty_s) begin
            case (phase_r)
                PH_A: begin
                    re_s  = sel_word(head_s, SL_AO_RE);
                    img_s = sel_word(head_s, SL_AO_IMG);
                end
                PH_B: begin
                    re_s  = sel_word(head_s, SL_BO_RE);
                    img_s = sel_word(head_s, SL_BO_IMG);
                end
                PH_C: begin
                    re_s  = sel_word(head_s, SL_CO_RE);
                    img_s = sel_word(head_s, SL_CO_IMG);
                end
                default: begin
                    re_s  = {W{1'b0}};
                    img_s = {W{1'b0}};
                end
            endcase
        end else begin
            // Empty FIFO holds stale data; present zeros instead.
            re_s  = {W{1'b0}};
            img_s = {W{1'b0}};
        end
    end

    // Output drive: everything is a function of registered state only.
    always_comb begin
        out_if.out_valid = !empty_s;
        out_if.out_re    = re_s;
        out_if.out_img   = img_s;
        out_if.out_idx   = phase_r;
        out_if.out_last  = (phase_r == PH_C);
        in_ready         = in_ready_s;
        overflow         = overflow_r;
        level            = level_r;
    end

    radix3_out_serializer_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en_s),
        .full   (full_s),
        .pop    (pop_s),
        .level  (level_r),
        .phase  (phase_r)
    );

endmodule

// -----------------------------------------------------------------------------
// radix3_out_serializer_chk
// Design-intent properties of the serializer: the credit scheme must keep
// capture away from a full FIFO, occupancy never exceeds DEPTH and the beat
// phase never takes the unused encoding.
//
// Ports:
//   clk, rst  clock and synchronous reset of the serializer
//   wr_en     delay-line capture strobe
//   full      FIFO full flag
//   pop       head triplet released this cycle
//   level     FIFO occupancy
//   phase     current beat phase
// -----------------------------------------------------------------------------
module radix3_out_serializer_chk #(
    parameter int DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   wr_en,
    input logic                   full,
    input logic                   pop,
    input logic [$clog2(DEPTH):0] level,
    input logic [1:0]             phase
);
    localparam logic [$clog2(DEPTH):0] DEPTH_C = ($clog2(DEPTH)+1)'(DEPTH);

    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (rst) !(wr_en && full && !pop)
    );

    a_level_bound: assert property (
        @(posedge clk) disable iff (rst) (level <= DEPTH_C)
    );

    a_phase_legal: assert property (
        @(posedge clk) disable iff (rst) (phase != 2'd3)
    );
endmodule

// File: tb/tb_radix3_out_serializer.sv
module tb_radix3_out_serializer;
    localparam int W       = 32;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 4;

    typedef logic [6*W-1:0] trip_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ao_re, ao_img, bo_re, bo_img, co_re, co_img;
    logic         overflow;
    logic [2:0]   level;

    radix3_out_serializer_if #(.W(W)) oif ();

    radix3_out_serializer #(
        .W       (W),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ao_re    (ao_re),
        .ao_img   (ao_img),
        .bo_re    (bo_re),
        .bo_img   (bo_img),
        .co_re    (co_re),
        .co_img   (co_img),
        .out_if   (oif),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: issue times in flight, buffered triplets, beat position.
    int    cyc = 0;
    int    iss_q[$];
    trip_t fq[$];
    int    beat = 0;
    int    credits = 0;
    bit    ovf_m = 1'b0;
    int    n_acc = 0;

    task automatic rand_data();
        ao_re = $urandom; ao_img = $urandom; bo_re = $urandom;
        bo_img = $urandom; co_re = $urandom; co_img = $urandom;
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        bit    acc, pop, cap;
        trip_t cur;
        acc = in_valid && (credits < DEPTH);
        cap = (iss_q.size() > 0) && (iss_q[0] == cyc - LATENCY);
        cur = {ao_re, ao_img, bo_re, bo_img, co_re, co_img};
        pop = 1'b0;
        if (rst) begin
            fq.delete(); iss_q.delete();
            beat = 0; credits = 0; ovf_m = 1'b0;
        end else begin
            if (in_valid && credits >= DEPTH) ovf_m = 1'b1;
            if (fq.size() > 0 && oif.out_ready) begin
                if (beat == 2) begin
                    pop = 1'b1; void'(fq.pop_front()); beat = 0;
                end else begin
                    beat++;
                end
            end
            if (cap) begin
                void'(iss_q.pop_front()); fq.push_back(cur);
            end
            if (acc) begin
                iss_q.push_back(cyc); n_acc++;
            end
            credits = credits + (acc ? 1 : 0) - (pop ? 1 : 0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic void model_out(output logic v, output logic [W-1:0] re,
                                      output logic [W-1:0] im, output logic [1:0] idx,
                                      output logic last);
        trip_t h;
        v    = (fq.size() > 0);
        re   = '0;
        im   = '0;
        idx  = 2'(beat);
        last = (beat == 2);
        if (v) begin
            h  = fq[0];
            re = h[(5-2*beat)*W +: W];
            im = h[(4-2*beat)*W +: W];
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; oif.out_ready = 1'b0;
        ao_re = '0; ao_img = '0; bo_re = '0; bo_img = '0; co_re = '0; co_img = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", oif.out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (oif.out_re !== 32'h0 || oif.out_img !== 32'h0) begin errors++; $display("FAIL rst_data got %h/%h want 0/0", oif.out_re, oif.out_img); end
        checks++; if (oif.out_idx !== 2'd0 || oif.out_last !== 1'b0) begin errors++; $display("FAIL rst_idx got %0d/%b want 0/0", oif.out_idx, oif.out_last); end
        repeat (10) tick();
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", oif.out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_overflow got %b want 0", overflow); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL idle_level got %0d want 0", level); end
    endtask

    task automatic test_single();
        logic [W-1:0] er [3];
        logic [W-1:0] ei [3];
        er = '{32'h3f800000, 32'h40000000, 32'h40400000};
        ei = '{32'h00000000, 32'hbf800000, 32'h3f000000};
        oif.out_ready = 1'b1;
        in_valid = 1'b1; rand_data(); tick();
        in_valid = 1'b0;
        repeat (LATENCY-1) begin rand_data(); tick(); end
        ao_re = er[0]; ao_img = ei[0]; bo_re = er[1]; bo_img = ei[1]; co_re = er[2]; co_img = ei[2];
        tick();
        rand_data();
        for (int k = 0; k < 3; k++) begin
            checks++; if (oif.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b want 1", k, oif.out_valid); end
            checks++; if (oif.out_re !== er[k] || oif.out_img !== ei[k]) begin errors++; $display("FAIL single_data beat %0d got %h/%h want %h/%h", k, oif.out_re, oif.out_img, er[k], ei[k]); end
            checks++; if (oif.out_idx !== 2'(k) || oif.out_last !== (k == 2)) begin errors++; $display("FAIL single_idx beat %0d got %0d/%b want %0d/%b", k, oif.out_idx, oif.out_last, k, k == 2); end
            tick();
        end
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL single_after got %b want 0", oif.out_valid); end
    endtask

    task automatic test_overflow();
        logic v, l; logic [W-1:0] r, m; logic [1:0] x;
        int guard;
        oif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; rand_data();
            checks++; if (in_ready !== (i < DEPTH)) begin errors++; $display("FAIL ovf_in_ready issue %0d got %b want %b", i, in_ready, i < DEPTH); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        guard = 0;
        while (fq.size() < DEPTH && guard < 20) begin rand_data(); tick(); guard++; end
        checks++; if (level !== 3'd4 || guard >= 20) begin errors++; $display("FAIL ovf_level got %0d want 4 (waited %0d)", level, guard); end
        oif.out_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            model_out(v, r, m, x, l);
            checks++; if (oif.out_valid !== v || oif.out_re !== r || oif.out_img !== m || oif.out_idx !== x || oif.out_last !== l)
                begin errors++; $display("FAIL ovf_beat %0d got v%b %h/%h i%0d l%b want v%b %h/%h i%0d l%b", b, oif.out_valid, oif.out_re, oif.out_img, oif.out_idx, oif.out_last, v, r, m, x, l); end
            rand_data(); tick();
        end
        checks++; if (oif.out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL ovf_drained got v%b lvl%0d want v0 lvl0", oif.out_valid, level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_stall();
        logic v, l; logic [W-1:0] r, m; logic [1:0] x;
        int guard;
        for (int c = 0; c < 120; c++) begin
            in_valid = 1'b1; oif.out_ready = cyc[0]; rand_data();
            model_out(v, r, m, x, l);
            checks++; if (oif.out_valid !== v || oif.out_re !== r || oif.out_img !== m || oif.out_idx !== x || oif.out_last !== l)
                begin errors++; $display("FAIL stall_beat c%0d got v%b %h/%h i%0d l%b want v%b %h/%h i%0d l%b", c, oif.out_valid, oif.out_re, oif.out_img, oif.out_idx, oif.out_last, v, r, m, x, l); end
            checks++; if (in_ready !== (credits < DEPTH) || level !== 3'(fq.size())) begin errors++; $display("FAIL stall_credit c%0d got rdy%b lvl%0d want rdy%b lvl%0d", c, in_ready, level, credits < DEPTH, fq.size()); end
            tick();
        end
        in_valid = 1'b0; oif.out_ready = 1'b1;
        guard = 0;
        while ((fq.size() > 0 || iss_q.size() > 0) && guard < 60) begin
            model_out(v, r, m, x, l);
            checks++; if (oif.out_valid !== v || oif.out_re !== r || oif.out_img !== m || oif.out_idx !== x)
                begin errors++; $display("FAIL stall_drain got v%b %h/%h i%0d want v%b %h/%h i%0d", oif.out_valid, oif.out_re, oif.out_img, oif.out_idx, v, r, m, x); end
            rand_data(); tick(); guard++;
        end
        checks++; if (guard >= 60 || oif.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain_end got v%b after %0d cycles want v0", oif.out_valid, guard); end
    endtask

    task automatic test_reset_mid();
        int guard;
        oif.out_ready = 1'b0;
        in_valid = 1'b1; rand_data(); tick();
        rand_data(); tick();
        in_valid = 1'b0;
        guard = 0;
        while (fq.size() < 2 && guard < 20) begin rand_data(); tick(); guard++; end
        in_valid = 1'b1; rand_data(); tick();
        in_valid = 1'b0; rst = 1'b1; rand_data(); tick();
        rst = 1'b0;
        checks++; if (oif.out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rmid_cleared got v%b lvl%0d want v0 lvl0", oif.out_valid, level); end
        checks++; if (overflow !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_flags got ovf%b rdy%b want ovf0 rdy1", overflow, in_ready); end
        repeat (LATENCY-2) begin rand_data(); tick(); end
        ao_re = 32'h42460000; bo_re = 32'h42460000; co_re = 32'h42460000;
        tick();
        oif.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (oif.out_valid !== 1'b0 || oif.out_re === 32'h42460000 || level !== 3'd0)
                begin errors++; $display("FAIL rmid_ghost c%0d got v%b re%h lvl%0d want v0 no 42460000 lvl0", c, oif.out_valid, oif.out_re, level); end
            rand_data(); tick();
        end
    endtask

    task automatic test_credit_wrap();
        logic v, l; logic [W-1:0] r, m; logic [1:0] x;
        int  guard, start;
        bit  hit;
        oif.out_ready = 1'b1;
        repeat (3) begin in_valid = 1'b1; rand_data(); tick(); end
        in_valid = 1'b0;
        hit = 1'b0; guard = 0;
        while (!hit && guard < 40) begin
            rand_data();
            if (fq.size() > 0 && beat == 2 && credits == DEPTH - 1) begin
                in_valid = 1'b1; hit = 1'b1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL same_cyc_ready got %b want 1", in_ready); end
            end
            tick(); guard++;
            in_valid = 1'b0;
        end
        checks++; if (!hit || in_ready !== 1'b1) begin errors++; $display("FAIL same_cyc_after got rdy%b hit%b want rdy1 hit1", in_ready, hit); end
        start = n_acc; guard = 0;
        while ((n_acc - start < 3*DEPTH + 2 || fq.size() > 0 || iss_q.size() > 0) && guard < 400) begin
            in_valid = (n_acc - start < 3*DEPTH + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            oif.out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            model_out(v, r, m, x, l);
            checks++; if (oif.out_valid !== v || oif.out_re !== r || oif.out_img !== m || oif.out_idx !== x || oif.out_last !== l)
                begin errors++; $display("FAIL wrap_beat g%0d got v%b %h/%h i%0d l%b want v%b %h/%h i%0d l%b", guard, oif.out_valid, oif.out_re, oif.out_img, oif.out_idx, oif.out_last, v, r, m, x, l); end
            checks++; if (in_ready !== (credits < DEPTH) || level !== 3'(fq.size())) begin errors++; $display("FAIL wrap_credit g%0d got rdy%b lvl%0d want rdy%b lvl%0d", guard, in_ready, level, credits < DEPTH, fq.size()); end
            tick(); guard++;
        end
        checks++; if (guard >= 400) begin errors++; $display("FAIL wrap_timeout got %0d cycles want < 400", guard); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_credit_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
